morra_match_controller: RTL and testbench
=========================================

Name: morra_match_controller

Overview:
- Sequences one MorraCinese game engine through a multi-game match.
- Collects moves from two player-side requesters over valid/ready handshakes, issues the engine's start/config pulse, and presents each move pair for exactly one cycle.
- Samples the engine's round and game results, tallies game wins, and declares the match winner.
- Sits between player-input logic and the engine instance; it is the only driver of the engine inputs.

Parameters:
- GAMES_TO_WIN, 2, game wins that end the match (best-of-3 by default).
- MAX_GAMES, 5, hard cap on games per match, draws included.
- TIMEOUT_CYCLES, 16, COLLECT cycles allowed before missing moves are forfeited.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- match_start  in  1  pulse; begins, or aborts and restarts, a match.
- cfg_rounds  in  4  round config, driven to the engine as {P1,P2} on start (engine plays cfg+4 rounds).
- p1_move  in  2  player 1 move; 00 is invalid.
- p1_valid  in  1  p1_move valid.
- p1_ready  out  1  controller accepts p1_move.
- p2_move  in  2  player 2 move; 00 is invalid.
- p2_valid  in  1  p2_move valid.
- p2_ready  out  1  controller accepts p2_move.
- eng_start  out  1  engine START.
- eng_p1  out  2  engine P1.
- eng_p2  out  2  engine P2.
- eng_round  in  2  engine ROUND result (00 null, 01 P1, 10 P2, 11 tie).
- eng_game  in  2  engine GAME result (00 running, 01 P1, 10 P2, 11 draw).
- busy  out  1  match in progress.
- match_done  out  1  high in DONE.
- match_winner  out  2  01 P1, 10 P2, 11 draw, 00 none.
- p1_games  out  3  games won by P1.
- p2_games  out  3  games won by P2.
- games_played  out  3  games completed.
- timeout_evt  out  1  one-cycle pulse when a COLLECT timeout forfeits a move.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0, including ready, eng_* and counters. Reset takes priority over every other event, including mid-match.
- States: IDLE, CONFIG, COLLECT, ISSUE, RESULT, DONE.
- IDLE:
  - eng_p1/eng_p2 = 00.
  - match_start -> CONFIG; clear p1_games, p2_games and games_played; latch cfg_rounds.
- CONFIG (1 cycle):
  - eng_start=1; {eng_p1,eng_p2}=latched cfg.
  - -> COLLECT; clear latched moves and the timeout counter.
- COLLECT:
  - pN_ready=1 until that player's move is latched.
  - Transfer occurs when valid&ready&move!=00.
  - A 00 move with valid high is dropped; ready stays high.
  - Players latch independently, in any order, or in the same cycle.
  - When both moves are latched -> ISSUE on the next edge.
  - Timeout counter increments each cycle in COLLECT. At TIMEOUT_CYCLES with a move missing: pulse timeout_evt, substitute 00 for the missing player(s), -> ISSUE.
- ISSUE (1 cycle):
  - eng_p1/eng_p2 = latched moves; ready=0.
  - -> RESULT.
- RESULT (1 cycle):
  - eng_p1/eng_p2 = 00; sample eng_round and eng_game at the end of the cycle.
  - eng_game==00 -> COLLECT, clearing latches and the timer.
  - eng_game!=00: increment games_played; 01 increments p1_games, 10 increments p2_games, 11 increments neither.
  - Then if either game count equals GAMES_TO_WIN, or games_played reaches MAX_GAMES -> DONE; else -> CONFIG for the next game with the same latched cfg.
- DONE:
  - match_done=1; busy=0; match_winner = the player with more games, 11 if equal.
  - Counters hold.
  - match_start -> CONFIG with a fresh cfg and cleared counters.
- busy=1 in CONFIG, COLLECT, ISSUE and RESULT.
- match_start in COLLECT, ISSUE or RESULT: abort. Clear counters and latches, -> CONFIG. No result of the aborted game is recorded.
- Counters are 3-bit and saturating. They cannot exceed MAX_GAMES given parameter limits GAMES_TO_WIN<=MAX_GAMES<=7.
- Latency: last move handshake -> eng_p* driven 1 cycle later -> result sampled 1 cycle after that.

Decomposition:
- Shared package morra_pkg:
  - move encoding constants: MOVE_NONE=00 plus the three move codes;
  - result codes NONE/P1/P2/TIE;
  - the state enum.
- One sub-module, morra_move_collector: per-player valid/ready latch with 00 rejection. Instantiate it twice; the timeout counter stays in the parent.

Test Plan:
- Reset mid-COLLECT with p1 latched: rst_n=0 for 1 cycle -> state IDLE, p1_ready=0, all counters 0, eng_* = 00.
- match_start, cfg=0000: CONFIG shows eng_start=1 and eng_p1/eng_p2=00/00. Then a move pair 01/11 -> ISSUE drives 01/11 for exactly 1 cycle. The model engine reports GAME=01 -> p1_games=1, games_played=1, next state CONFIG.
- p2 presents 00 with valid=1, then 10 two cycles later -> first presentation dropped (p2_ready stays 1), second accepted; ISSUE shows eng_p2=10.
- p1 never valid: after 16 COLLECT cycles -> timeout_evt=1 for 1 cycle, ISSUE drives eng_p1=00.
- Engine reports GAME 01, 10, 11, 11, 01 -> after the 5th game state DONE, p1_games=2, p2_games=1, games_played=5, match_winner=01.
- match_start during RESULT of game 2 -> no tally change from that game, counters cleared, eng_start pulses the next cycle.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared definitions for the MorraCinese match controller: move and result
// encodings, the controller state enum and small counter/decision helpers.
package morra_pkg;

    // Move encoding on the player and engine move buses.
    localparam logic [1:0] MOVE_NONE    = 2'b00;
    localparam logic [1:0] MOVE_SASSO   = 2'b01;
    localparam logic [1:0] MOVE_CARTA   = 2'b10;
    localparam logic [1:0] MOVE_FORBICE = 2'b11;

    // Result encoding shared by engine ROUND/GAME and match_winner.
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONFIG  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_RESULT  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // True for the three playable moves; 00 is never a legal move.
    function automatic logic is_move(input logic [1:0] mv);
        return (mv == MOVE_SASSO) || (mv == MOVE_CARTA) || (mv == MOVE_FORBICE);
    endfunction

    // 3-bit saturating increment for the game tallies.
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        return (v == 3'd7) ? v : v + 3'd1;
    endfunction

    // Match winner from the two game tallies; equal tallies are a draw.
    function automatic logic [1:0] winner_of(input logic [2:0] a, input logic [2:0] b);
        logic [1:0] w;
        if (a > b) begin
            w = RES_P1;
        end else if (b > a) begin
            w = RES_P2;
        end else begin
            w = RES_TIE;
        end
        return w;
    endfunction

endpackage

// File: rtl/morra_move_collector.sv
// Per-player move latch: raises ready when armed, accepts one non-zero move
// over a valid/ready handshake and holds it until flushed or re-armed.
module morra_move_collector
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       flush,
    input  logic [1:0] move,
    input  logic       valid,
    output logic       ready,
    output logic       take,
    output logic       latched,
    output logic [1:0] move_q
);

    logic       ready_r;
    logic       latched_r;
    logic [1:0] move_r;
    logic       take_s;

    // A 00 move with valid high is simply ignored, leaving ready raised.
    assign take_s = ready_r & valid & is_move(move);

    // Handshake latch; flush wins over arm so leaving COLLECT always drops ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_r   <= 1'b0;
            latched_r <= 1'b0;
            move_r    <= MOVE_NONE;
        end else if (flush) begin
            ready_r   <= 1'b0;
            latched_r <= 1'b0;
            move_r    <= MOVE_NONE;
        end else if (arm) begin
            ready_r   <= 1'b1;
            latched_r <= 1'b0;
            move_r    <= MOVE_NONE;
        end else if (take_s) begin
            ready_r   <= 1'b0;
            latched_r <= 1'b1;
            move_r    <= move;
        end else begin
            ready_r   <= ready_r;
            latched_r <= latched_r;
            move_r    <= move_r;
        end
    end

    assign ready   = ready_r;
    assign take    = take_s;
    assign latched = latched_r;
    assign move_q  = move_r;

endmodule

// File: rtl/morra_match_controller.sv
// Match sequencer for a single MorraCinese engine: configures each game,
// gathers both players' moves, presents them for one cycle, tallies game
// results and declares the match winner.
module morra_match_controller
    import morra_pkg::*;
#(
    parameter int GAMES_TO_WIN   = 2,
    parameter int MAX_GAMES      = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       match_start,
    input  logic [3:0] cfg_rounds,
    input  logic [1:0] p1_move,
    input  logic       p1_valid,
    output logic       p1_ready,
    input  logic [1:0] p2_move,
    input  logic       p2_valid,
    output logic       p2_ready,
    output logic       eng_start,
    output logic [1:0] eng_p1,
    output logic [1:0] eng_p2,
    input  logic [1:0] eng_round,
    input  logic [1:0] eng_game,
    output logic       busy,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic [2:0] p1_games,
    output logic [2:0] p2_games,
    output logic [2:0] games_played,
    output logic       timeout_evt
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]     WIN_CNT  = 3'(GAMES_TO_WIN);
    localparam logic [2:0]     MAX_CNT  = 3'(MAX_GAMES);

    state_t          state_r;
    logic [3:0]      cfg_r;
    logic [TW-1:0]   timer_r;
    logic            eng_start_r;
    logic [1:0]      eng_p1_r;
    logic [1:0]      eng_p2_r;
    logic            busy_r;
    logic            match_done_r;
    logic [1:0]      match_winner_r;
    logic [2:0]      p1_games_r;
    logic [2:0]      p2_games_r;
    logic [2:0]      games_played_r;
    logic            timeout_evt_r;
    logic [1:0]      last_round_unused_r;

    logic            p1_take_s;
    logic            p2_take_s;
    logic            p1_latched_s;
    logic            p2_latched_s;
    logic [1:0]      p1_q_s;
    logic [1:0]      p2_q_s;
    logic [1:0]      p1_sel_s;
    logic [1:0]      p2_sel_s;
    logic            both_s;
    logic            timed_out_s;
    logic            restart_s;
    logic            arm_s;
    logic            flush_s;
    logic [2:0]      p1_games_nx_s;
    logic [2:0]      p2_games_nx_s;
    logic [2:0]      games_played_nx_s;
    logic            finish_s;

    morra_move_collector u_p1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (arm_s),
        .flush   (flush_s),
        .move    (p1_move),
        .valid   (p1_valid),
        .ready   (p1_ready),
        .take    (p1_take_s),
        .latched (p1_latched_s),
        .move_q  (p1_q_s)
    );

    morra_move_collector u_p2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (arm_s),
        .flush   (flush_s),
        .move    (p2_move),
        .valid   (p2_valid),
        .ready   (p2_ready),
        .take    (p2_take_s),
        .latched (p2_latched_s),
        .move_q  (p2_q_s)
    );

    // Move pair for ISSUE: a handshake completing this cycle is used directly so
    // the engine sees the pair one cycle after the last handshake; a player with
    // nothing latched contributes 00.
    assign p1_sel_s    = p1_take_s ? p1_move : p1_q_s;
    assign p2_sel_s    = p2_take_s ? p2_move : p2_q_s;
    assign both_s      = (p1_latched_s | p1_take_s) & (p2_latched_s | p2_take_s);
    assign timed_out_s = (timer_r == TO_LAST);

    // Tallies as they would stand after recording the engine's GAME result.
    assign p1_games_nx_s     = (eng_game == RES_P1) ? sat_inc3(p1_games_r) : p1_games_r;
    assign p2_games_nx_s     = (eng_game == RES_P2) ? sat_inc3(p2_games_r) : p2_games_r;
    assign games_played_nx_s = sat_inc3(games_played_r);
    assign finish_s          = (p1_games_nx_s == WIN_CNT) || (p2_games_nx_s == WIN_CNT) ||
                               (games_played_nx_s == MAX_CNT);

    // Decode start/abort requests and the collector arm/flush strobes from the state.
    always_comb begin
        restart_s = 1'b0;
        arm_s     = 1'b0;
        flush_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ISSUE: begin
                restart_s = match_start;
            end
            ST_CONFIG: begin
                arm_s = 1'b1;
            end
            ST_COLLECT: begin
                restart_s = match_start;
                flush_s   = match_start | both_s | timed_out_s;
            end
            ST_RESULT: begin
                restart_s = match_start;
                flush_s   = match_start;
                arm_s     = ~match_start & (eng_game == RES_NONE);
            end
            default: begin
                restart_s = 1'b0;
            end
        endcase
    end

    // Match FSM with registered engine, status and tally outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r             <= ST_IDLE;
            cfg_r               <= 4'd0;
            timer_r             <= '0;
            eng_start_r         <= 1'b0;
            eng_p1_r            <= MOVE_NONE;
            eng_p2_r            <= MOVE_NONE;
            busy_r              <= 1'b0;
            match_done_r        <= 1'b0;
            match_winner_r      <= RES_NONE;
            p1_games_r          <= 3'd0;
            p2_games_r          <= 3'd0;
            games_played_r      <= 3'd0;
            timeout_evt_r       <= 1'b0;
            last_round_unused_r <= RES_NONE;
        end else begin
            // Pulses and engine moves return to idle values unless a transition sets them.
            eng_start_r   <= 1'b0;
            eng_p1_r      <= MOVE_NONE;
            eng_p2_r      <= MOVE_NONE;
            timeout_evt_r <= 1'b0;
            if (restart_s) begin
                // Fresh match (or abort of the current one): nothing from the old game survives.
                state_r        <= ST_CONFIG;
                cfg_r          <= cfg_rounds;
                timer_r        <= '0;
                eng_start_r    <= 1'b1;
                eng_p1_r       <= cfg_rounds[3:2];
                eng_p2_r       <= cfg_rounds[1:0];
                busy_r         <= 1'b1;
                match_done_r   <= 1'b0;
                match_winner_r <= RES_NONE;
                p1_games_r     <= 3'd0;
                p2_games_r     <= 3'd0;
                games_played_r <= 3'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= ST_IDLE;
                    end
                    ST_CONFIG: begin
                        state_r <= ST_COLLECT;
                        timer_r <= '0;
                    end
                    ST_COLLECT: begin
                        if (both_s) begin
                            state_r  <= ST_ISSUE;
                            eng_p1_r <= p1_sel_s;
                            eng_p2_r <= p2_sel_s;
                        end else if (timed_out_s) begin
                            state_r       <= ST_ISSUE;
                            timeout_evt_r <= 1'b1;
                            eng_p1_r      <= p1_sel_s;
                            eng_p2_r      <= p2_sel_s;
                        end else begin
                            timer_r <= timer_r + TW'(1);
                        end
                    end
                    ST_ISSUE: begin
                        state_r <= ST_RESULT;
                    end
                    ST_RESULT: begin
                        last_round_unused_r <= eng_round;
                        if (eng_game == RES_NONE) begin
                            state_r <= ST_COLLECT;
                            timer_r <= '0;
                        end else begin
                            p1_games_r     <= p1_games_nx_s;
                            p2_games_r     <= p2_games_nx_s;
                            games_played_r <= games_played_nx_s;
                            if (finish_s) begin
                                state_r        <= ST_DONE;
                                busy_r         <= 1'b0;
                                match_done_r   <= 1'b1;
                                match_winner_r <= winner_of(p1_games_nx_s, p2_games_nx_s);
                            end else begin
                                state_r     <= ST_CONFIG;
                                eng_start_r <= 1'b1;
                                eng_p1_r    <= cfg_r[3:2];
                                eng_p2_r    <= cfg_r[1:0];
                            end
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_DONE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign eng_start    = eng_start_r;
    assign eng_p1       = eng_p1_r;
    assign eng_p2       = eng_p2_r;
    assign busy         = busy_r;
    assign match_done   = match_done_r;
    assign match_winner = match_winner_r;
    assign p1_games     = p1_games_r;
    assign p2_games     = p2_games_r;
    assign games_played = games_played_r;
    assign timeout_evt  = timeout_evt_r;

endmodule

// File: tb/tb_morra_match_controller.sv
// Self-checking bench for morra_match_controller: directed and randomized
// matches checked against a transaction-level model of the match rules.
module tb_morra_match_controller;

    localparam int TO = 16;
    localparam int GW = 2;
    localparam int MG = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       match_start;
    logic [3:0] cfg_rounds;
    logic [1:0] p1_move;
    logic       p1_valid;
    logic       p1_ready;
    logic [1:0] p2_move;
    logic       p2_valid;
    logic       p2_ready;
    logic       eng_start;
    logic [1:0] eng_p1;
    logic [1:0] eng_p2;
    logic [1:0] eng_round;
    logic [1:0] eng_game;
    logic       busy;
    logic       match_done;
    logic [1:0] match_winner;
    logic [2:0] p1_games;
    logic [2:0] p2_games;
    logic [2:0] games_played;
    logic       timeout_evt;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int         m_p1w;
    int         m_p2w;
    int         m_played;
    logic [3:0] m_cfg;

    morra_match_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .match_start  (match_start),
        .cfg_rounds   (cfg_rounds),
        .p1_move      (p1_move),
        .p1_valid     (p1_valid),
        .p1_ready     (p1_ready),
        .p2_move      (p2_move),
        .p2_valid     (p2_valid),
        .p2_ready     (p2_ready),
        .eng_start    (eng_start),
        .eng_p1       (eng_p1),
        .eng_p2       (eng_p2),
        .eng_round    (eng_round),
        .eng_game     (eng_game),
        .busy         (busy),
        .match_done   (match_done),
        .match_winner (match_winner),
        .p1_games     (p1_games),
        .p2_games     (p2_games),
        .games_played (games_played),
        .timeout_evt  (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_winner();
        if (m_p1w > m_p2w) return 2'b01;
        else if (m_p2w > m_p1w) return 2'b10;
        else return 2'b11;
    endfunction

    function automatic int rnd_delay();
        if ($urandom_range(0, 9) == 0) return 99;
        else return int'($urandom_range(0, 4));
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_p1g"}, 8'(p1_games), 8'(m_p1w));
        chk({tag, "_p2g"}, 8'(p2_games), 8'(m_p2w));
        chk({tag, "_played"}, 8'(games_played), 8'(m_played));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_done"}, 8'(match_done), 8'd0);
        chk({tag, "_winner"}, 8'(match_winner), 8'd0);
        chk({tag, "_p1rdy"}, 8'(p1_ready), 8'd0);
        chk({tag, "_p2rdy"}, 8'(p2_ready), 8'd0);
        chk({tag, "_estart"}, 8'(eng_start), 8'd0);
        chk({tag, "_ep1"}, 8'(eng_p1), 8'd0);
        chk({tag, "_ep2"}, 8'(eng_p2), 8'd0);
        chk({tag, "_tmo"}, 8'(timeout_evt), 8'd0);
        chk({tag, "_p1g"}, 8'(p1_games), 8'd0);
        chk({tag, "_p2g"}, 8'(p2_games), 8'd0);
        chk({tag, "_played"}, 8'(games_played), 8'd0);
    endtask

    // Expectations for a CONFIG cycle: start pulse, cfg split onto the move buses.
    task automatic chk_config(input string tag);
        chk({tag, "_estart"}, 8'(eng_start), 8'd1);
        chk({tag, "_ep1"}, 8'(eng_p1), 8'(m_cfg[3:2]));
        chk({tag, "_ep2"}, 8'(eng_p2), 8'(m_cfg[1:0]));
        chk({tag, "_busy"}, 8'(busy), 8'd1);
        chk({tag, "_done"}, 8'(match_done), 8'd0);
        chk({tag, "_p1rdy"}, 8'(p1_ready), 8'd0);
        chk_counts(tag);
    endtask

    // Start a match from IDLE/DONE; returns positioned in the first COLLECT cycle.
    task automatic start_match(input logic [3:0] cfg);
        match_start = 1'b1;
        cfg_rounds  = cfg;
        tick();
        match_start = 1'b0;
        cfg_rounds  = 4'($urandom);
        m_cfg = cfg; m_p1w = 0; m_p2w = 0; m_played = 0;
        chk_config("cfg");
        tick();
    endtask

    // One engine round, entered in the first COLLECT cycle. dN = COLLECT cycle in
    // which player N presents its move (>= TO: never); bad2 = cycle p2 presents 00.
    task automatic do_round(input logic [1:0] m1, input int d1, input logic [1:0] m2,
                            input int d2, input int bad2, input logic [1:0] game,
                            input bit abort, input logic [3:0] new_cfg, output bit done);
        int  last;
        int  ncyc;
        bit  tmo;
        last = (d1 > d2) ? d1 : d2;
        tmo  = (last >= TO);
        ncyc = tmo ? TO : last + 1;
        done = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            p1_valid = (c == d1);
            p1_move  = (c == d1) ? m1 : 2'($urandom);
            if (c == bad2) begin
                p2_valid = 1'b1;
                p2_move  = 2'b00;
            end else begin
                p2_valid = (c == d2);
                p2_move  = (c == d2) ? m2 : 2'($urandom);
            end
            chk("col_p1rdy", 8'(p1_ready), 8'(c <= d1));
            chk("col_p2rdy", 8'(p2_ready), 8'(c <= d2));
            chk("col_tmo", 8'(timeout_evt), 8'd0);
            chk("col_busy", 8'(busy), 8'd1);
            tick();
        end
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        // ISSUE
        chk("iss_ep1", 8'(eng_p1), 8'((d1 < ncyc) ? m1 : 2'b00));
        chk("iss_ep2", 8'(eng_p2), 8'((d2 < ncyc) ? m2 : 2'b00));
        chk("iss_tmo", 8'(timeout_evt), 8'(tmo));
        chk("iss_p1rdy", 8'(p1_ready), 8'd0);
        chk("iss_p2rdy", 8'(p2_ready), 8'd0);
        tick();
        // RESULT
        chk("res_ep1", 8'(eng_p1), 8'd0);
        chk("res_ep2", 8'(eng_p2), 8'd0);
        chk("res_tmo", 8'(timeout_evt), 8'd0);
        eng_game  = game;
        eng_round = 2'($urandom);
        if (abort) begin
            match_start = 1'b1;
            cfg_rounds  = new_cfg;
        end
        tick();
        eng_game    = 2'($urandom);
        match_start = 1'b0;
        if (abort) begin
            m_cfg = new_cfg; m_p1w = 0; m_p2w = 0; m_played = 0;
            chk_config("abort");
            tick();
        end else if (game == 2'b00) begin
            chk("run_busy", 8'(busy), 8'd1);
            chk("run_estart", 8'(eng_start), 8'd0);
            chk_counts("run");
        end else begin
            m_played++;
            if (game == 2'b01) m_p1w++;
            if (game == 2'b10) m_p2w++;
            if (m_p1w == GW || m_p2w == GW || m_played == MG) begin
                chk("done_flag", 8'(match_done), 8'd1);
                chk("done_busy", 8'(busy), 8'd0);
                chk("done_winner", 8'(match_winner), 8'(exp_winner()));
                chk_counts("done");
                done = 1'b1;
            end else begin
                chk_config("next");
                tick();
            end
        end
    endtask

    initial begin
        bit         done;
        int         rounds;
        int         d1;
        int         d2;
        int         bad;
        logic [1:0] g;

        rst_n = 1'b0; match_start = 1'b0; cfg_rounds = 4'd0;
        p1_move = 2'b00; p1_valid = 1'b0; p2_move = 2'b00; p2_valid = 1'b0;
        eng_round = 2'b00; eng_game = 2'b00;
        tick();
        tick();
        chk_idle("rst");
        rst_n = 1'b1;
        tick();
        chk_idle("idle");

        // Reset in the middle of COLLECT with p1 already latched
        start_match(4'b0110);
        p1_valid = 1'b1; p1_move = 2'b01;
        tick();
        p1_valid = 1'b0;
        chk("mid_p1rdy", 8'(p1_ready), 8'd0);
        chk("mid_p2rdy", 8'(p2_ready), 8'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_idle("rst_mid");
        tick();
        chk_idle("post_rst");

        // Directed match: GAME 01, (running round), 10, 11, 11, 01
        start_match(4'b0000);
        do_round(2'b01, 0, 2'b11, 0, -1, 2'b01, 1'b0, 4'd0, done);
        do_round(2'b10, 1, 2'b10, 3, 1, 2'b00, 1'b0, 4'd0, done);
        do_round(2'b11, 99, 2'b11, 2, -1, 2'b10, 1'b0, 4'd0, done);
        do_round(2'b01, 2, 2'b10, 0, -1, 2'b11, 1'b0, 4'd0, done);
        do_round(2'b11, 0, 2'b01, 1, -1, 2'b11, 1'b0, 4'd0, done);
        do_round(2'b10, 3, 2'b11, 3, -1, 2'b01, 1'b0, 4'd0, done);
        tick();
        tick();
        chk("hold_done", 8'(match_done), 8'd1);
        chk("hold_winner", 8'(match_winner), 8'b01);
        chk_counts("hold");

        // Randomized matches
        for (int m = 0; m < 6; m++) begin
            start_match(4'($urandom));
            done   = 1'b0;
            rounds = 0;
            while (!done) begin
                rounds++;
                g = 2'($urandom_range(0, 3));
                if (rounds > 20 && g == 2'b00) g = 2'b11;
                d1  = rnd_delay();
                d2  = rnd_delay();
                bad = -1;
                if (d2 < TO && $urandom_range(0, 3) == 0) begin
                    bad = d2;
                    d2  = d2 + 2;
                end
                do_round(2'($urandom_range(1, 3)), d1, 2'($urandom_range(1, 3)), d2, bad,
                         g, 1'b0, 4'd0, done);
            end
        end

        // Abort during RESULT of game 2, then finish the restarted match
        start_match(4'b1001);
        do_round(2'b01, 0, 2'b10, 1, -1, 2'b10, 1'b0, 4'd0, done);
        do_round(2'b11, 2, 2'b01, 0, -1, 2'b01, 1'b1, 4'b0111, done);
        do_round(2'b10, 1, 2'b01, 1, -1, 2'b01, 1'b0, 4'd0, done);
        do_round(2'b01, 0, 2'b11, 4, -1, 2'b01, 1'b0, 4'd0, done);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
